// File: rtl/serial_uge4_pkg.sv
// Shared types and sizing helpers for the bit-serial unsigned >= comparator.
package serial_uge4_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Counter width for a WIDTH-beat frame; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_uge4_if.sv
// Beat-in / result-out handshake bundle for serial_uge4.
interface serial_uge4_if;
  logic I0;
  logic I1;
  logic IN_VALID;
  logic IN_READY;
  logic FLUSH;
  logic O;
  logic EQ;
  logic O_VALID;
  logic O_READY;

  modport master (
    output I0, I1, IN_VALID, FLUSH, O_READY,
    input  IN_READY, O, EQ, O_VALID
  );

  modport slave (
    input  I0, I1, IN_VALID, FLUSH, O_READY,
    output IN_READY, O, EQ, O_VALID
  );
endinterface

// File: rtl/serial_uge_bitcell.sv
// MSB-first decision cell: latches the first differing bit pair of a frame.
module serial_uge_bitcell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic last_i,
  input  logic i0_i,
  input  logic i1_i,
  output logic res_o,
  output logic eq_o
);

  logic decided_q;
  logic gt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
    end else if (en_i) begin
      if (last_i) begin
        decided_q <= 1'b0;
        gt_q      <= 1'b0;
      end else if (!decided_q && (i0_i != i1_i)) begin
        decided_q <= 1'b1;
        gt_q      <= i0_i;
      end
    end
  end

  // Frame result as it would stand if the current beat were the last one.
  always_comb begin
    res_o = decided_q ? gt_q : (i0_i | ~i1_i);
    eq_o  = ~decided_q & (i0_i ~^ i1_i);
  end

endmodule

// File: rtl/serial_uge4.sv
// Bit-serial unsigned A >= B / A == B comparator with result hold until consumed.
module serial_uge4
  import serial_uge4_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         CLK,
  input  logic         RESET,
  serial_uge4_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          o_q;
  logic          eq_q;
  logic          accept;
  logic          last_beat;
  logic          res;
  logic          res_eq;

  assign accept    = bus.IN_VALID && (state_q == COLLECT) && !bus.FLUSH;
  assign last_beat = (cnt_q == LAST_CNT);
  assign cnt_d     = last_beat ? '0 : cnt_q + 1'b1;

  serial_uge_bitcell u_cell (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (bus.FLUSH),
    .en_i   (accept),
    .last_i (last_beat),
    .i0_i   (bus.I0),
    .i1_i   (bus.I1),
    .res_o  (res),
    .eq_o   (res_eq)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      eq_q    <= 1'b0;
    end else if (bus.FLUSH) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (last_beat) begin
              o_q     <= res;
              eq_q    <= res_eq;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.O_READY) state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.O        = o_q;
  assign bus.EQ       = eq_q;
  assign bus.O_VALID  = (state_q == HOLD);
  assign bus.IN_READY = (state_q == COLLECT);

endmodule

// File: tb/tb_serial_uge4.sv
// Self-checking bench for serial_uge4: directed scenarios plus random frames vs a word-level model.
module tb_serial_uge4;

  logic CLK = 1'b0;
  logic RESET;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  serial_uge4_if bus ();
  serial_uge4_if bus1 ();

  serial_uge4 #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  serial_uge4 #(.WIDTH(1)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1)
  );

  task automatic idle();
    bus.IN_VALID = 1'b0;
    bus.I0       = 1'b0;
    bus.I1       = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.O_READY  = 1'b0;
  endtask

  task automatic beat(input logic a, input logic b);
    bus.IN_VALID = 1'b1;
    bus.I0       = a;
    bus.I1       = b;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b);
    for (int i = 3; i >= 0; i--) beat(a[i], b[i]);
  endtask

  task automatic consume();
    bus.O_READY = 1'b1;
    @(negedge CLK);
    bus.O_READY = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    tests++;
    if ({bus.O, bus.EQ, bus.O_VALID, bus.IN_READY} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_state: got O/EQ/OV/IR=%b required 0001",
               {bus.O, bus.EQ, bus.O_VALID, bus.IN_READY});
    end
    send_frame(4'b0110, 4'b0101);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b110) begin
      fails++;
      $display("FAIL reset_fresh_frame: got OV/O/EQ=%b required 110", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
  endtask

  task automatic test_greater();
    send_frame(4'b1010, 4'b1001);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b110) begin
      fails++;
      $display("FAIL greater_1010_1001: got OV/O/EQ=%b required 110", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
    tests++;
    if (bus.O_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL consume_release: got OV=%b IR=%b required OV=0 IR=1", bus.O_VALID, bus.IN_READY);
    end
    send_frame(4'b0111, 4'b1000);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b100) begin
      fails++;
      $display("FAIL less_0111_1000: got OV/O/EQ=%b required 100", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
  endtask

  task automatic test_equal();
    send_frame(4'b0110, 4'b0110);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b111) begin
      fails++;
      $display("FAIL equal_0110: got OV/O/EQ=%b required 111", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
    send_frame(4'b0000, 4'b0001);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b100) begin
      fails++;
      $display("FAIL last_bit_0000_0001: got OV/O/EQ=%b required 100", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
  endtask

  task automatic test_backpressure();
    send_frame(4'b1100, 4'b0011);
    bus.IN_VALID = 1'b1;
    bus.I0       = 1'b0;
    bus.I1       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({bus.IN_READY, bus.O_VALID, bus.O, bus.EQ} !== 4'b0110) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: got IR/OV/O/EQ=%b required 0110", i,
                 {bus.IN_READY, bus.O_VALID, bus.O, bus.EQ});
      end
      @(negedge CLK);
    end
    bus.IN_VALID = 1'b0;
    consume();
    tests++;
    if (bus.IN_READY !== 1'b1 || bus.O_VALID !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: got IR=%b OV=%b required IR=1 OV=0", bus.IN_READY, bus.O_VALID);
    end
    send_frame(4'b0001, 4'b0001);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b111) begin
      fails++;
      $display("FAIL backpressure_next_frame: got OV/O/EQ=%b required 111", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
  endtask

  task automatic test_flush();
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    bus.FLUSH    = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.I0       = 1'b1;
    bus.I1       = 1'b0;
    @(negedge CLK);
    bus.FLUSH    = 1'b0;
    bus.IN_VALID = 1'b0;
    send_frame(4'b0001, 4'b0010);
    tests++;
    if ({bus.O_VALID, bus.O, bus.EQ} !== 3'b100) begin
      fails++;
      $display("FAIL flush_partial: got OV/O/EQ=%b required 100", {bus.O_VALID, bus.O, bus.EQ});
    end
    consume();
    send_frame(4'b1111, 4'b1111);
    bus.FLUSH   = 1'b1;
    bus.O_READY = 1'b1;
    @(negedge CLK);
    bus.FLUSH   = 1'b0;
    bus.O_READY = 1'b0;
    tests++;
    if ({bus.O_VALID, bus.IN_READY, bus.O, bus.EQ} !== 4'b0111) begin
      fails++;
      $display("FAIL flush_hold: got OV/IR/O/EQ=%b required 0111",
               {bus.O_VALID, bus.IN_READY, bus.O, bus.EQ});
    end
  endtask

  task automatic test_random();
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    int         n = 0;
    int         frames = 0;
    int         cyc = 0;
    logic       ev = 1'b0;
    logic       eo = 1'b0;
    logic       eeq = 1'b0;
    logic       v, r, x0, x1;
    idle();
    while (frames < 2000 && cyc < 60000) begin
      cyc++;
      tests++;
      if (bus.O_VALID !== ev || bus.IN_READY !== !ev) begin
        fails++;
        $display("FAIL random_handshake cyc %0d: got OV=%b IR=%b required OV=%b IR=%b",
                 cyc, bus.O_VALID, bus.IN_READY, ev, !ev);
      end
      if (ev) begin
        tests++;
        if ({bus.O, bus.EQ} !== {eo, eeq}) begin
          fails++;
          $display("FAIL random_result frame %0d: got O/EQ=%b required %b (A=%h B=%h)",
                   frames, {bus.O, bus.EQ}, {eo, eeq}, a, b);
        end
      end
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      x0 = 1'($urandom);
      x1 = ($urandom_range(0, 3) == 0) ? ~x0 : x0;
      bus.IN_VALID = v;
      bus.I0       = x0;
      bus.I1       = x1;
      bus.O_READY  = r;
      if (!ev && v) begin
        a = {a[2:0], x0};
        b = {b[2:0], x1};
        n++;
        if (n == 4) begin
          n   = 0;
          ev  = 1'b1;
          eo  = (a >= b);
          eeq = (a == b);
          frames++;
        end
      end else if (ev && r) begin
        ev = 1'b0;
      end
      @(negedge CLK);
    end
    idle();
    tests++;
    if (frames < 2000) begin
      fails++;
      $display("FAIL random_budget: got %0d frames required 2000", frames);
    end
  endtask

  task automatic test_width1();
    logic ev = 1'b0;
    logic eo = 1'b0;
    logic eeq = 1'b0;
    logic v, r, x0, x1;
    for (int c = 0; c < 400; c++) begin
      tests++;
      if (bus1.O_VALID !== ev || (ev && {bus1.O, bus1.EQ} !== {eo, eeq})) begin
        fails++;
        $display("FAIL width1 cyc %0d: got OV/O/EQ=%b required OV=%b O/EQ=%b",
                 c, {bus1.O_VALID, bus1.O, bus1.EQ}, ev, {eo, eeq});
      end
      v  = 1'($urandom);
      r  = 1'($urandom);
      x0 = 1'($urandom);
      x1 = 1'($urandom);
      bus1.IN_VALID = v;
      bus1.I0       = x0;
      bus1.I1       = x1;
      bus1.O_READY  = r;
      if (!ev && v) begin
        ev  = 1'b1;
        eo  = (x0 >= x1);
        eeq = (x0 == x1);
      end else if (ev && r) begin
        ev = 1'b0;
      end
      @(negedge CLK);
    end
    bus1.IN_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    bus1.IN_VALID = 1'b0;
    bus1.I0       = 1'b0;
    bus1.I1       = 1'b0;
    bus1.FLUSH    = 1'b0;
    bus1.O_READY  = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    test_reset();
    test_greater();
    test_equal();
    test_backpressure();
    test_flush();
    test_random();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
